// File: rtl/aes_batch_scheduler.sv
// Batch sequencer between the AHB slave buffers and the AES round core.
// Pops NUM_BLOCKS blocks, runs each through the core, writes results and flags done or error.
module aes_batch_scheduler #(
  parameter int NUM_BLOCKS   = 4,
  parameter int CORE_TIMEOUT = 64
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          key_valid,
  input  logic                          mode_dec,
  input  logic [$clog2(NUM_BLOCKS):0]   in_count,
  input  logic [127:0]                  in_block,
  output logic                          in_pop,
  output logic                          core_start,
  output logic                          core_decrypt,
  output logic [127:0]                  core_data,
  input  logic                          core_done,
  input  logic [127:0]                  core_result,
  input  logic                          out_full,
  output logic                          out_wr,
  output logic [$clog2(NUM_BLOCKS)-1:0] out_idx,
  output logic [127:0]                  out_data,
  output logic                          busy,
  output logic                          batch_done,
  output logic                          err,
  input  logic                          err_clr
);

  localparam int IDX_W  = $clog2(NUM_BLOCKS);
  localparam int CNT_W  = IDX_W + 1;
  localparam int WAIT_W = $clog2(CORE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_STORE, S_DONE, S_ERR
  } state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    blk_cnt_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic                in_pop_next, core_start_next, out_wr_next;
  logic                busy_next, batch_done_next, err_next;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // Key loss outranks both core_done and timeout, so a result that arrives
  // together with key loss never reaches STORE and is never written.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (key_valid && (in_count >= CNT_W'(NUM_BLOCKS)) && !out_full)
                 state_next = S_LOAD;
      S_LOAD:  state_next = key_valid ? S_ISSUE : S_ERR;
      S_ISSUE: state_next = key_valid ? S_WAIT : S_ERR;
      S_WAIT: begin
        if (!key_valid)                                      state_next = S_ERR;
        else if (core_done)                                  state_next = S_STORE;
        else if (wait_cnt_reg == WAIT_W'(CORE_TIMEOUT - 1))  state_next = S_ERR;
      end
      S_STORE: begin
        if (!key_valid)                                 state_next = S_ERR;
        else if (blk_cnt_reg == IDX_W'(NUM_BLOCKS - 1)) state_next = S_DONE;
        else                                            state_next = S_LOAD;
      end
      S_DONE:  state_next = S_IDLE;
      S_ERR:   if (err_clr) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each pulse
  // lines up with the cycle spent in its state without any input-to-output path.
  always_comb begin
    in_pop_next     = (state_next == S_LOAD);
    core_start_next = (state_next == S_ISSUE);
    out_wr_next     = (state_next == S_STORE);
    batch_done_next = (state_next == S_DONE);
    err_next        = (state_next == S_ERR);
    busy_next       = (state_next == S_LOAD) || (state_next == S_ISSUE) ||
                      (state_next == S_WAIT) || (state_next == S_STORE);
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      in_pop       <= 1'b0;
      core_start   <= 1'b0;
      out_wr       <= 1'b0;
      busy         <= 1'b0;
      batch_done   <= 1'b0;
      err          <= 1'b0;
      core_decrypt <= 1'b0;
      core_data    <= '0;
      out_idx      <= '0;
      out_data     <= '0;
      blk_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
    end else begin
      in_pop     <= in_pop_next;
      core_start <= core_start_next;
      out_wr     <= out_wr_next;
      busy       <= busy_next;
      batch_done <= batch_done_next;
      err        <= err_next;
      case (state_reg)
        S_IDLE: if (state_next == S_LOAD) begin
          core_decrypt <= mode_dec;
          blk_cnt_reg  <= '0;
        end
        S_LOAD:  if (state_next == S_ISSUE) core_data <= in_block;
        S_ISSUE: wait_cnt_reg <= '0;
        S_WAIT: begin
          wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          if (state_next == S_STORE) begin
            out_data <= core_result;
            out_idx  <= blk_cnt_reg;
          end
        end
        S_STORE: if (state_next == S_LOAD) blk_cnt_reg <= blk_cnt_reg + IDX_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_batch_scheduler.sv
// Self-checking bench for aes_batch_scheduler: input buffer, core stub with latency L,
// and an output scoreboard, all advanced one negedge at a time by tick().
module tb_aes_batch_scheduler;

  localparam int NB = 4;
  localparam logic [127:0] K_ENC = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [127:0] K_DEC = 128'h3C3C5A5AA5A5C3C30123456789ABCDEF;

  typedef struct packed {
    logic [1:0]   idx;
    logic [127:0] data;
  } exp_t;

  logic         tb_HCLK = 1'b0;
  logic         HRESETn, key_valid, mode_dec, core_done, out_full, err_clr;
  logic [2:0]   in_count;
  logic [127:0] in_block, core_result;
  logic         in_pop, core_start, core_decrypt, out_wr, busy, batch_done, err;
  logic [127:0] core_data, out_data;
  logic [1:0]   out_idx;

  int errors = 0, checks = 0, cyc = 0;
  int pops, starts, writes, done_cnt, dec_ones, err_cyc, done_cyc;
  int core_cnt = 0, lat = 10;
  int pop_cyc[$], start_cyc[$];
  logic         pop_pend = 1'b0, core_en = 1'b1;
  logic [127:0] core_pend = '0;
  logic [127:0] in_q[$];
  exp_t         exp_q[$];

  always #5 tb_HCLK = ~tb_HCLK;

  aes_batch_scheduler #(.NUM_BLOCKS(NB), .CORE_TIMEOUT(64)) dut (
    .HCLK(tb_HCLK), .HRESETn(HRESETn), .key_valid(key_valid), .mode_dec(mode_dec),
    .in_count(in_count), .in_block(in_block), .in_pop(in_pop), .core_start(core_start),
    .core_decrypt(core_decrypt), .core_data(core_data), .core_done(core_done),
    .core_result(core_result), .out_full(out_full), .out_wr(out_wr), .out_idx(out_idx),
    .out_data(out_data), .busy(busy), .batch_done(batch_done), .err(err), .err_clr(err_clr)
  );

  // Core stub: encrypt xors a key, decrypt swaps halves and xors another key.
  function automatic logic [127:0] core_fn(input logic [127:0] blk, input logic dec);
    return dec ? ({blk[63:0], blk[127:64]} ^ K_DEC) : (blk ^ K_ENC);
  endfunction

  task automatic upd_in();
    in_count = 3'(in_q.size());
    in_block = (in_q.size() > 0) ? in_q[0] : '0;
  endtask

  task automatic reset_counts();
    pops = 0; starts = 0; writes = 0; done_cnt = 0; dec_ones = 0;
    err_cyc = -1; done_cyc = -1;
    pop_cyc.delete(); start_cyc.delete();
  endtask

  task automatic fill(input int n, input logic dec, input int nexp);
    logic [127:0] blk;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      blk = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_q.push_back(blk);
      if (i < nexp) begin
        e.idx  = 2'(i);
        e.data = core_fn(blk, dec);
        exp_q.push_back(e);
      end
    end
    upd_in();
  endtask

  // One clock: sample outputs at the negedge, then drive inputs for the next posedge.
  task automatic tick();
    exp_t e;
    @(negedge tb_HCLK);
    cyc++;
    if (!HRESETn) begin
      core_cnt = 0;
      pop_pend = 1'b0;
    end else begin
      if (pop_pend && in_q.size() > 0) in_q.delete(0);
      pop_pend = in_pop;
      if (in_pop) begin pops++; pop_cyc.push_back(cyc); end
      if (out_wr) begin
        writes++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_wr_unexpected: got idx=%0d data=%h, expected no write", out_idx, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_idx !== e.idx || out_data !== e.data) begin
            errors++;
            $display("FAIL out_wr_data: got idx=%0d data=%h, expected idx=%0d data=%h",
                     out_idx, out_data, e.idx, e.data);
          end else
            $display("write idx=%0d data=%h ok at cycle %0d", out_idx, out_data, cyc);
        end
      end
      if (batch_done) begin done_cnt++; done_cyc = cyc; end
      if (err && err_cyc < 0) err_cyc = cyc;
    end
    core_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0 && core_en) begin
        core_done   = 1'b1;
        core_result = core_pend;
      end
    end
    if (core_start && HRESETn) begin
      starts++;
      start_cyc.push_back(cyc);
      if (core_decrypt) dec_ones++;
      core_cnt  = lat;
      core_pend = core_fn(core_data, core_decrypt);
    end
    upd_in();
  endtask

  task automatic run_until_done(input int budget, input string name);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin tick(); n++; end
    if (done_cnt == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no batch_done within %0d cycles, expected batch_done", name, budget);
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    repeat (2) tick();
    checks++;
    if ({in_pop, core_start, core_decrypt, out_wr, busy, batch_done, err, out_idx} !== 9'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, expected 0",
               {in_pop, core_start, core_decrypt, out_wr, busy, batch_done, err, out_idx});
    end
    checks++;
    if (core_data !== '0) begin errors++; $display("FAIL reset_core_data: got %h, expected 0", core_data); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h, expected 0", out_data); end
    HRESETn = 1'b1;
    reset_counts();
    key_valid = 1'b0;
    fill(4, 1'b0, 0);
    repeat (10) tick();
    checks++;
    if (pops !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL no_key_idle: got pops=%0d busy=%b, expected 0 and 0", pops, busy);
    end
    in_q.delete();
    upd_in();
    tick();
  endtask

  task automatic test_encrypt();
    reset_counts();
    lat = 10; mode_dec = 1'b0; key_valid = 1'b1;
    fill(4, 1'b0, 4);
    run_until_done(200, "encrypt");
    repeat (2) tick();
    checks++;
    if (pops != 4 || starts != 4 || writes != 4) begin
      errors++;
      $display("FAIL encrypt_counts: got pops=%0d starts=%0d writes=%0d, expected 4 4 4", pops, starts, writes);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (start_cyc.size() < 4 || start_cyc[i] - start_cyc[i-1] != 13) begin
        errors++;
        $display("FAIL encrypt_spacing%0d: got %0d, expected 13", i,
                 (start_cyc.size() > i) ? start_cyc[i] - start_cyc[i-1] : -1);
      end
    end
    // last IDLE cycle is one before the first pop; batch_done lands 4*(10+3)+1 after it
    checks++;
    if (pop_cyc.size() == 0 || done_cyc != (pop_cyc[0] - 1) + 53) begin
      errors++;
      $display("FAIL encrypt_latency: got done at %0d, expected %0d", done_cyc,
               (pop_cyc.size() > 0) ? pop_cyc[0] + 52 : -1);
    end
    checks++;
    if (dec_ones != 0 || done_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL encrypt_mode: got dec=%0d done=%0d left=%0d, expected 0 1 0", dec_ones, done_cnt, exp_q.size());
    end
  endtask

  task automatic test_mode_latch();
    int n = 0;
    reset_counts();
    lat = 3; mode_dec = 1'b1;
    fill(4, 1'b1, 4);
    while (done_cnt == 0 && n < 200) begin
      tick(); n++;
      if (starts == 2) mode_dec = 1'b0;
    end
    repeat (2) tick();
    checks++;
    if (dec_ones != 4 || writes != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL mode_latch: got dec=%0d writes=%0d left=%0d, expected 4 4 0", dec_ones, writes, exp_q.size());
    end
    mode_dec = 1'b0;
  endtask

  task automatic test_backpressure();
    reset_counts();
    lat = 2; out_full = 1'b1;
    fill(4, 1'b0, 4);
    repeat (8) tick();
    checks++;
    if (pops != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: got pops=%0d busy=%b, expected 0 0", pops, busy);
    end
    out_full = 1'b0;
    tick();
    checks++;
    if (in_pop !== 1'b1) begin errors++; $display("FAIL bp_release: got in_pop=%b, expected 1", in_pop); end
    run_until_done(100, "bp");
    repeat (2) tick();
    checks++;
    if (writes != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_writes: got writes=%0d left=%0d, expected 4 0", writes, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    reset_counts();
    core_en = 1'b0;
    fill(4, 1'b0, 0);
    while (err_cyc < 0 && n < 150) begin tick(); n++; end
    // ISSUE is start_cyc[0]; 64 WAIT cycles follow, err shows one cycle later
    checks++;
    if (start_cyc.size() == 0 || err_cyc != start_cyc[0] + 65) begin
      errors++;
      $display("FAIL timeout_time: got err at %0d, expected %0d", err_cyc,
               (start_cyc.size() > 0) ? start_cyc[0] + 65 : -1);
    end
    repeat (5) tick();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || writes != 0 || pops != 1 || starts != 1) begin
      errors++;
      $display("FAIL timeout_state: got err=%b busy=%b writes=%0d pops=%0d starts=%0d, expected 1 0 0 1 1",
               err, busy, writes, pops, starts);
    end
    in_q.delete();
    upd_in();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got err=%b busy=%b, expected 0 0", err, busy);
    end
    core_en = 1'b1;
  endtask

  task automatic test_key_loss();
    int n = 0;
    reset_counts();
    lat = 4;
    fill(4, 1'b0, 1);
    while (starts < 2 && n < 100) begin tick(); n++; end
    tick();
    key_valid = 1'b0;
    repeat (6) tick();
    checks++;
    if (err !== 1'b1 || writes != 1 || exp_q.size() != 0 || starts != 2) begin
      errors++;
      $display("FAIL key_loss: got err=%b writes=%0d left=%0d starts=%0d, expected 1 1 0 2",
               err, writes, exp_q.size(), starts);
    end
    in_q.delete();
    upd_in();
    key_valid = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL key_loss_clear: got err=%b, expected 0", err); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    reset_counts();
    lat = 4;
    fill(4, 1'b0, 2);
    while (starts < 3 && n < 100) begin tick(); n++; end
    tick();
    HRESETn = 1'b0;
    tick();
    checks++;
    if ({in_pop, core_start, core_decrypt, out_wr, busy, batch_done, err, out_idx} !== 9'd0 ||
        core_data !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_mid: got ctrl=%b core_data=%h out_data=%h, expected all 0",
               {in_pop, core_start, core_decrypt, out_wr, busy, batch_done, err, out_idx}, core_data, out_data);
    end
    HRESETn = 1'b1;
    in_q.delete();
    upd_in();
    repeat (6) tick();
    checks++;
    if (writes != 2 || exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: got writes=%0d left=%0d busy=%b, expected 2 0 0", writes, exp_q.size(), busy);
    end
  endtask

  initial begin
    HRESETn = 1'b0; key_valid = 1'b0; mode_dec = 1'b0; core_done = 1'b0; out_full = 1'b0;
    err_clr = 1'b0; in_count = '0; in_block = '0; core_result = '0;
    reset_counts();
    test_reset();
    test_encrypt();
    test_mode_latch();
    test_backpressure();
    test_timeout();
    test_key_loss();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
